// File: rtl/store_sink_if.sv
// Store-bus and drain-stream bundle for store_sink.
// The core/host side uses the master modport. store_sink uses the slave modport.
interface store_sink_if;
  logic        MemWrite;
  logic [31:0] DataAddress;
  logic [31:0] WriteData;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        done;
  logic        pass;
  logic        overflow;
  logic [15:0] store_count;

  modport master (
    output MemWrite, DataAddress, WriteData, out_ready,
    input  out_valid, out_addr, out_data, done, pass, overflow, store_count
  );

  modport slave (
    input  MemWrite, DataAddress, WriteData, out_ready,
    output out_valid, out_addr, out_data, done, pass, overflow, store_count
  );
endinterface

// File: rtl/store_sink.sv
// Captures every core store into a small FIFO drained over valid/ready.
// It also tracks the first tohost store as sticky done/pass flags.
module store_sink #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [31:0] TOHOST_ADDR = 32'd100,
  parameter logic [31:0] PASS_VALUE  = 32'd102400
) (
  input logic         clk,
  input logic         reset,
  store_sink_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StWait, StDone} host_st_e;

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [31:0]  addr_mem [DEPTH];
  logic [31:0]  data_mem [DEPTH];
  logic         empty, full, push, pop;
  logic         overflow_q, done_q, pass_q;
  logic [15:0]  store_count_q;
  host_st_e     host_st_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && bus.out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the store.
  assign push  = bus.MemWrite && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      store_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (bus.MemWrite && !push) overflow_q <= 1'b1;
      if (bus.MemWrite && (store_count_q != 16'hFFFF)) store_count_q <= store_count_q + 16'd1;
    end
  end

  // Storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q[AW-1:0]] <= bus.DataAddress;
      data_mem[wr_ptr_q[AW-1:0]] <= bus.WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_st_q <= StWait;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (host_st_q)
        StWait: begin
          if (bus.MemWrite && (bus.DataAddress == TOHOST_ADDR)) begin
            host_st_q <= StDone;
            done_q    <= 1'b1;
            pass_q    <= (bus.WriteData == PASS_VALUE);
          end
        end
        StDone:  host_st_q <= StDone;
        default: host_st_q <= StWait;
      endcase
    end
  end

  // The head is forced to zero when empty, so out_addr and out_data read as zero after reset.
  assign bus.out_valid   = !empty;
  assign bus.out_addr    = empty ? 32'd0 : addr_mem[rd_ptr_q[AW-1:0]];
  assign bus.out_data    = empty ? 32'd0 : data_mem[rd_ptr_q[AW-1:0]];
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.overflow    = overflow_q;
  assign bus.store_count = store_count_q;

endmodule

// File: tb/tb_store_sink.sv
// Randomized and directed checks of store_sink against a queue-based reference model.
module tb_store_sink;

  localparam int unsigned DEPTH  = 8;
  localparam logic [31:0] TOHOST = 32'd100;
  localparam logic [31:0] PASSV  = 32'd102400;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_sink_if sif ();

  store_sink #(
    .DEPTH      (DEPTH),
    .TOHOST_ADDR(TOHOST),
    .PASS_VALUE (PASSV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sif)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [63:0] mq[$];
  logic        m_done, m_pass, m_ovf;
  int unsigned m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("out_valid", 64'(sif.out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("out_addr", 64'(sif.out_addr), 64'(mq[0][63:32]));
      check("out_data", 64'(sif.out_data), 64'(mq[0][31:0]));
    end
    check("done", 64'(sif.done), 64'(m_done));
    if (m_done) check("pass", 64'(sif.pass), 64'(m_pass));
    check("overflow", 64'(sif.overflow), 64'(m_ovf));
    check("store_count", 64'(sif.store_count), 64'(m_cnt));
  endtask

  // Called just after a falling edge; checks that everything clears immediately.
  task automatic do_reset();
    sif.MemWrite  = 1'b0;
    sif.out_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_valid", 64'(sif.out_valid), 64'd0);
    check("rst_addr", 64'(sif.out_addr), 64'd0);
    check("rst_data", 64'(sif.out_data), 64'd0);
    check("rst_done", 64'(sif.done), 64'd0);
    check("rst_pass", 64'(sif.pass), 64'd0);
    check("rst_ovf", 64'(sif.overflow), 64'd0);
    check("rst_count", 64'(sif.store_count), 64'd0);
    mq.delete();
    m_done = 1'b0;
    m_pass = 1'b0;
    m_ovf  = 1'b0;
    m_cnt  = 0;
    #1;
    reset = 1'b1;
  endtask

  // Applies one cycle of inputs, advances the model, then compares on the falling edge.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                      input logic rdy);
    bit do_pop;
    sif.MemWrite    = mw;
    sif.DataAddress = a;
    sif.WriteData   = d;
    sif.out_ready   = rdy;
    do_pop = (mq.size() != 0) && rdy;
    if (mw) begin
      if (m_cnt < 65535) m_cnt++;
      if (!m_done && a == TOHOST) begin
        m_done = 1'b1;
        m_pass = (d == PASSV);
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (mw) begin
      if (mq.size() < DEPTH) mq.push_back({a, d});
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int unsigned pct [4] = '{20, 50, 80, 95};
    reset           = 1'b0;
    sif.MemWrite    = 1'b0;
    sif.DataAddress = '0;
    sif.WriteData   = '0;
    sif.out_ready   = 1'b0;
    m_done = 1'b0;
    m_pass = 1'b0;
    m_ovf  = 1'b0;
    m_cnt  = 0;
    repeat (2) @(negedge clk);
    do_reset();

    // Basic store, then a single pop.
    step(1'b1, 32'd4, 32'd7, 1'b0);
    check("basic_valid", 64'(sif.out_valid), 64'd1);
    check("basic_addr", 64'(sif.out_addr), 64'd4);
    check("basic_data", 64'(sif.out_data), 64'd7);
    check("basic_count", 64'(sif.store_count), 64'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1);
    check("basic_pop", 64'(sif.out_valid), 64'd0);

    // Pass verdict, then a later tohost store must not change it.
    step(1'b1, TOHOST, PASSV, 1'b0);
    check("pass_done", 64'(sif.done), 64'd1);
    check("pass_pass", 64'(sif.pass), 64'd1);
    check("pass_head", 64'({sif.out_addr, sif.out_data}), {TOHOST, PASSV});
    step(1'b1, TOHOST, 32'd5, 1'b0);
    check("pass_sticky", 64'(sif.pass), 64'd1);

    @(negedge clk);
    do_reset();
    step(1'b1, TOHOST, 32'd102399, 1'b0);
    check("fail_done", 64'(sif.done), 64'd1);
    check("fail_pass", 64'(sif.pass), 64'd0);

    // Overflow: nine stores into eight slots.
    @(negedge clk);
    do_reset();
    for (int i = 1; i <= 9; i++) step(1'b1, 32'(i * 4), 32'(i), 1'b0);
    check("ovf_flag", 64'(sif.overflow), 64'd1);
    check("ovf_count", 64'(sif.store_count), 64'd9);
    for (int i = 1; i <= 8; i++) begin
      check("ovf_drain", 64'(sif.out_data), 64'(i));
      step(1'b0, 32'd0, 32'd0, 1'b1);
    end
    check("ovf_empty", 64'(sif.out_valid), 64'd0);

    // Full FIFO with a simultaneous push and pop.
    @(negedge clk);
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 32'd8, 32'(i), 1'b0);
    step(1'b1, 32'd8, 32'd10, 1'b1);
    check("full_ovf", 64'(sif.overflow), 64'd0);
    check("full_occ", 64'(mq.size()), 64'(DEPTH));
    for (int i = 2; i <= 8; i++) step(1'b0, 32'd0, 32'd0, 1'b1);
    check("full_last", 64'(sif.out_data), 64'd10);
    step(1'b0, 32'd0, 32'd0, 1'b1);
    check("full_empty", 64'(sif.out_valid), 64'd0);

    // Reset mid-stream.
    @(negedge clk);
    do_reset();
    step(1'b1, 32'd12, 32'd3, 1'b0);
    step(1'b1, TOHOST, PASSV, 1'b0);
    step(1'b1, 32'd16, 32'd4, 1'b0);
    do_reset();
    step(1'b1, 32'd8, 32'd1, 1'b0);
    check("mid_head", 64'({sif.out_addr, sif.out_data}), {32'd8, 32'd1});
    step(1'b0, 32'd0, 32'd0, 1'b1);
    check("mid_only", 64'(sif.out_valid), 64'd0);

    // Random traffic at several consumer duty cycles.
    for (int seg = 0; seg < 4; seg++) begin
      @(negedge clk);
      do_reset();
      for (int c = 0; c < 500; c++) begin
        logic        mw, rdy;
        logic [31:0] a, d;
        mw  = ($urandom_range(0, 9) < 6);
        a   = ($urandom_range(0, 7) == 0) ? TOHOST : $urandom;
        d   = ($urandom_range(0, 1) == 0) ? PASSV : $urandom;
        rdy = ($urandom_range(0, 99) < pct[seg]);
        step(mw, a, d, rdy);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
